// File: rtl/lcd_timing_gen_if.sv
// Raster timing bundle between the LCD timing generator (master) and its consumers (slave).
// The enable request flows into the generator; every other signal is produced by it.
interface lcd_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          enable;
    logic          tick;
    logic          pclk;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          active;
    logic          line_start;
    logic          next_frame;
    logic [15:0]   frame_count;
    logic          hs;
    logic          vs;
    logic          data_enable;

    modport master (
        input  enable,
        output tick, pclk, x, y, active, line_start, next_frame, frame_count, hs, vs, data_enable
    );

    modport slave (
        output enable,
        input  tick, pclk, x, y, active, line_start, next_frame, frame_count, hs, vs, data_enable
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD raster generator: divided pixel tick, h/v counters, frame gating, sync/DE decode.
// x/y/active register on the tick; hs/vs/data_enable trail them by PIPE_DELAY ticks; enable acts only at frame wrap.
module lcd_timing_gen #(
    parameter int H_ACTIVE       = 800,
    parameter int H_FP           = 40,
    parameter int H_SYNC         = 48,
    parameter int H_BP           = 40,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 13,
    parameter int V_SYNC         = 3,
    parameter int V_BP           = 29,
    parameter int CLOCK_DIVIDE   = 2,
    parameter int PIPE_DELAY     = 2,
    parameter bit HS_ACTIVE_HIGH = 1'b0,
    parameter bit VS_ACTIVE_HIGH = 1'b0,
    parameter int XW             = 10,
    parameter int YW             = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    lcd_timing_gen_if.master lcd
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLOCK_DIVIDE);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDE - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLOCK_DIVIDE / 2);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

    if (CLOCK_DIVIDE < 2) begin : g_bad_divide
        $error("lcd_timing_gen: CLOCK_DIVIDE must be at least 2");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
        $error("lcd_timing_gen: PIPE_DELAY must be within 0..15");
    end
    if (H_TOTAL > (1 << XW)) begin : g_bad_xw
        $error("lcd_timing_gen: H_TOTAL does not fit in XW bits");
    end
    if (V_TOTAL > (1 << YW)) begin : g_bad_yw
        $error("lcd_timing_gen: V_TOTAL does not fit in YW bits");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // Sync bits are carried as "asserted" flags; polarity is applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic          pclk_q, pclk_d;
    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          next_frame_q, next_frame_d;
    logic [15:0]   frame_q, frame_d;
    sync_t         pipe_q [0:PIPE_DELAY];
    sync_t         pipe_d [0:PIPE_DELAY];
    sync_t         dec;

    function automatic sync_t decode(input logic [XW-1:0] h, input logic [YW-1:0] v);
        int    hi;
        int    vi;
        sync_t s;
        hi   = int'(h);
        vi   = int'(v);
        s.hs = (hi >= H_ACTIVE + H_FP) && (hi < H_ACTIVE + H_FP + H_SYNC);
        s.vs = (vi >= V_ACTIVE + V_FP) && (vi < V_ACTIVE + V_FP + V_SYNC);
        s.de = (hi < H_ACTIVE) && (vi < V_ACTIVE);
        return s;
    endfunction

    // tick_q/pclk_q are registered decodes of div_d, so they always equal the decode of div_q.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        tick_d = (div_d == DIV_LAST);
        pclk_d = (div_d >= DIV_HALF);
    end

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        frame_d      = frame_q;
        active_d     = active_q;
        line_start_d = 1'b0;
        next_frame_d = 1'b0;
        pipe_d       = pipe_q;
        dec          = '0;
        if (tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    h_d = '0;
                    v_d = '0;
                    if (lcd.enable) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (h_q == H_LAST) begin
                        h_d          = '0;
                        line_start_d = 1'b1;
                        if (v_q == V_LAST) begin
                            v_d          = '0;
                            next_frame_d = 1'b1;
                            frame_d      = frame_q + 16'd1;
                            if (!lcd.enable) state_d = ST_IDLE;
                        end else begin
                            v_d = v_q + YW'(1);
                        end
                    end else begin
                        h_d = h_q + XW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Idle feeds blank entries so the delay line drains cleanly.
            if (state_d == ST_RUN) dec = decode(h_d, v_d);
            active_d  = dec.de;
            pipe_d[0] = dec;
            for (int i = 1; i <= PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            tick_q       <= 1'b0;
            pclk_q       <= 1'b0;
            h_q          <= '0;
            v_q          <= '0;
            active_q     <= 1'b0;
            line_start_q <= 1'b0;
            next_frame_q <= 1'b0;
            frame_q      <= '0;
            pipe_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
            pclk_q       <= pclk_d;
            h_q          <= h_d;
            v_q          <= v_d;
            active_q     <= active_d;
            line_start_q <= line_start_d;
            next_frame_q <= next_frame_d;
            frame_q      <= frame_d;
            pipe_q       <= pipe_d;
        end
    end

    assign lcd.tick        = tick_q;
    assign lcd.pclk        = pclk_q;
    assign lcd.x           = h_q;
    assign lcd.y           = v_q;
    assign lcd.active      = active_q;
    assign lcd.line_start  = line_start_q;
    assign lcd.next_frame  = next_frame_q;
    assign lcd.frame_count = frame_q;
    assign lcd.hs          = HS_ACTIVE_HIGH ? pipe_q[PIPE_DELAY].hs : ~pipe_q[PIPE_DELAY].hs;
    assign lcd.vs          = VS_ACTIVE_HIGH ? pipe_q[PIPE_DELAY].vs : ~pipe_q[PIPE_DELAY].vs;
    assign lcd.data_enable = pipe_q[PIPE_DELAY].de;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: default geometry, a tiny 8x5 raster, delay/polarity/divider variants.
// Expected values come from hand-derived raster formulas indexed by clocks since reset release.
module tb_lcd_timing_gen;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    lcd_timing_gen_if if_def ();
    lcd_timing_gen_if if_s0 ();
    lcd_timing_gen_if if_s3 ();
    lcd_timing_gen_if if_p ();

    assign if_def.enable = enable;
    assign if_s0.enable  = enable;
    assign if_s3.enable  = enable;
    assign if_p.enable   = enable;

    lcd_timing_gen u_def (.clock(clock), .reset_n(reset_n), .lcd(if_def));

    lcd_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1),
                     .V_BP(1), .PIPE_DELAY(0)) u_s0 (.clock(clock), .reset_n(reset_n), .lcd(if_s0));

    lcd_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1),
                     .V_BP(1), .PIPE_DELAY(3)) u_s3 (.clock(clock), .reset_n(reset_n), .lcd(if_s3));

    lcd_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1),
                     .V_BP(1), .PIPE_DELAY(0), .CLOCK_DIVIDE(4), .HS_ACTIVE_HIGH(1), .VS_ACTIVE_HIGH(0))
        u_p (.clock(clock), .reset_n(reset_n), .lcd(if_p));

    // Release reset on a falling edge; the k-th falling edge afterwards follows the k-th rising edge.
    task automatic start(input bit en);
        @(negedge clock);
        reset_n = 1'b0;
        enable  = en;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge clock);
        n_total++;
        if ({if_def.tick, if_def.pclk, if_def.active, if_def.line_start, if_def.next_frame, if_def.data_enable} !== 6'b0)
            $display("FAIL reset_strobes got %b want 000000", {if_def.tick, if_def.pclk, if_def.active,
                     if_def.line_start, if_def.next_frame, if_def.data_enable});
        else n_pass++;
        n_total++;
        if ({if_def.x, if_def.y, if_def.frame_count} !== 36'd0)
            $display("FAIL reset_counters got x=%0d y=%0d fc=%0d want 0 0 0", if_def.x, if_def.y, if_def.frame_count);
        else n_pass++;
        n_total++;
        if ({if_def.hs, if_def.vs} !== 2'b11)
            $display("FAIL reset_sync_low_active got %b want 11", {if_def.hs, if_def.vs});
        else n_pass++;
        n_total++;
        if ({if_p.hs, if_p.vs} !== 2'b01)
            $display("FAIL reset_sync_mixed_polarity got %b want 01", {if_p.hs, if_p.vs});
        else n_pass++;
    endtask

    task automatic test_defaults();
        int   n, d, dh;
        bit   hs_on, de_on;
        logic [19:0] pos_exp;
        logic [5:0]  sig_exp, sig_got;
        start(1'b1);
        for (int k = 1; k <= 1860; k++) begin
            @(negedge clock);
            n_total++;
            if ({if_def.tick, if_def.pclk} !== {2{k % 2 == 1}})
                $display("FAIL def_divider k=%0d got %b want %b", k, {if_def.tick, if_def.pclk}, {2{k % 2 == 1}});
            else n_pass++;
            if (k >= 2 && k % 2 == 0) begin
                n     = (k - 2) / 2;
                d     = (n >= 2) ? n - 2 : 0;
                dh    = d % 928;
                hs_on = (n >= 2) && dh >= 840 && dh < 888;
                de_on = (n >= 2) && dh < 800;
                pos_exp = {10'(n % 928), 10'(n / 928)};
                n_total++;
                if ({if_def.x, if_def.y} !== pos_exp)
                    $display("FAIL def_pos n=%0d got x=%0d y=%0d want x=%0d y=%0d", n, if_def.x, if_def.y,
                             pos_exp[19:10], pos_exp[9:0]);
                else n_pass++;
                sig_exp = {(n % 928) < 800, !hs_on, 1'b1, de_on, n == 928, 1'b0};
                sig_got = {if_def.active, if_def.hs, if_def.vs, if_def.data_enable, if_def.line_start, if_def.next_frame};
                n_total++;
                if (sig_got !== sig_exp)
                    $display("FAIL def_sync n=%0d got %b want %b", n, sig_got, sig_exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        start(1'b1);
        repeat (603) @(negedge clock);
        n_total++;
        if (if_def.x !== 10'd300 || if_def.tick !== 1'b1)
            $display("FAIL async_pre x=%0d tick=%b want x=300 tick=1", if_def.x, if_def.tick);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({if_def.tick, if_def.pclk, if_def.active, if_def.line_start, if_def.next_frame, if_def.data_enable,
             if_def.x, if_def.y, if_def.frame_count} !== 42'd0)
            $display("FAIL async_clear tick=%b pclk=%b act=%b de=%b x=%0d y=%0d fc=%0d want all 0", if_def.tick,
                     if_def.pclk, if_def.active, if_def.data_enable, if_def.x, if_def.y, if_def.frame_count);
        else n_pass++;
        n_total++;
        if ({if_def.hs, if_def.vs} !== 2'b11)
            $display("FAIL async_sync got %b want 11", {if_def.hs, if_def.vs});
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_total++;
        if (if_def.x !== 10'd0 || if_def.active !== 1'b1)
            $display("FAIL async_restart0 x=%0d active=%b want x=0 active=1", if_def.x, if_def.active);
        else n_pass++;
        repeat (2) @(negedge clock);
        n_total++;
        if (if_def.x !== 10'd1 || if_def.y !== 10'd0)
            $display("FAIL async_restart1 x=%0d y=%0d want x=1 y=0", if_def.x, if_def.y);
        else n_pass++;
    endtask

    task automatic test_small_pd0();
        int   n, eh, ev;
        bit   run, a, ls, nf;
        logic [3:0]  sync_exp;
        logic [19:0] str_exp;
        start(1'b1);
        for (int k = 1; k <= 172; k++) begin
            @(negedge clock);
            run = (k >= 2);
            n   = run ? (k - 2) / 2 : 0;
            eh  = n % 8;
            ev  = (n / 8) % 5;
            a   = run && eh < 4 && ev < 2;
            ls  = run && (k % 2 == 0) && n > 0 && (n % 8 == 0);
            nf  = run && (k % 2 == 0) && n > 0 && (n % 40 == 0);
            n_total++;
            if ({if_s0.x, if_s0.y} !== {10'(eh), 10'(ev)})
                $display("FAIL s0_pos k=%0d got x=%0d y=%0d want x=%0d y=%0d", k, if_s0.x, if_s0.y, eh, ev);
            else n_pass++;
            sync_exp = {a, !(run && (eh == 5 || eh == 6)), !(run && ev == 3), a};
            n_total++;
            if ({if_s0.active, if_s0.hs, if_s0.vs, if_s0.data_enable} !== sync_exp)
                $display("FAIL s0_sync k=%0d got %b want %b", k,
                         {if_s0.active, if_s0.hs, if_s0.vs, if_s0.data_enable}, sync_exp);
            else n_pass++;
            str_exp = {k % 2 == 1, k % 2 == 1, ls, nf, 16'(n / 40)};
            n_total++;
            if ({if_s0.tick, if_s0.pclk, if_s0.line_start, if_s0.next_frame, if_s0.frame_count} !== str_exp)
                $display("FAIL s0_strobes k=%0d got %h want %h", k,
                         {if_s0.tick, if_s0.pclk, if_s0.line_start, if_s0.next_frame, if_s0.frame_count}, str_exp);
            else n_pass++;
        end
    endtask

    task automatic test_pipe_delay();
        int   n, eh, ev, d, dh, dv;
        bit   run, dok;
        logic [3:0] sync_exp;
        start(1'b1);
        for (int k = 1; k <= 172; k++) begin
            @(negedge clock);
            run = (k >= 2);
            n   = run ? (k - 2) / 2 : 0;
            eh  = n % 8;
            ev  = (n / 8) % 5;
            dok = run && n >= 3;
            d   = dok ? n - 3 : 0;
            dh  = d % 8;
            dv  = (d / 8) % 5;
            n_total++;
            if ({if_s3.x, if_s3.y} !== {10'(eh), 10'(ev)})
                $display("FAIL s3_pos k=%0d got x=%0d y=%0d want x=%0d y=%0d", k, if_s3.x, if_s3.y, eh, ev);
            else n_pass++;
            sync_exp = {run && eh < 4 && ev < 2, !(dok && (dh == 5 || dh == 6)), !(dok && dv == 3),
                        dok && dh < 4 && dv < 2};
            n_total++;
            if ({if_s3.active, if_s3.hs, if_s3.vs, if_s3.data_enable} !== sync_exp)
                $display("FAIL s3_delayed_sync k=%0d got %b want %b", k,
                         {if_s3.active, if_s3.hs, if_s3.vs, if_s3.data_enable}, sync_exp);
            else n_pass++;
        end
    endtask

    task automatic test_polarity();
        int   n, eh, ev;
        bit   run;
        logic [5:0] sig_exp, sig_got;
        start(1'b1);
        for (int k = 1; k <= 184; k++) begin
            @(negedge clock);
            run = (k >= 4);
            n   = run ? (k - 4) / 4 : 0;
            eh  = n % 8;
            ev  = (n / 8) % 5;
            n_total++;
            if ({if_p.x, if_p.y} !== {10'(eh), 10'(ev)})
                $display("FAIL pol_pos k=%0d got x=%0d y=%0d want x=%0d y=%0d", k, if_p.x, if_p.y, eh, ev);
            else n_pass++;
            sig_exp = {k % 4 == 3, k % 4 >= 2, run && (eh == 5 || eh == 6), !(run && ev == 3),
                       run && eh < 4 && ev < 2, run && (k % 4 == 0) && n > 0 && (n % 8 == 0)};
            sig_got = {if_p.tick, if_p.pclk, if_p.hs, if_p.vs, if_p.data_enable, if_p.line_start};
            n_total++;
            if (sig_got !== sig_exp)
                $display("FAIL pol_signals k=%0d got %b want %b", k, sig_got, sig_exp);
            else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        int   n, eh, ev;
        bit   run, pulse_ok, a;
        logic [3:0]  sync_exp;
        logic [17:0] str_exp;
        start(1'b1);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (k < 2) begin
                run = 1'b0; n = 0;
            end else if (k <= 161) begin
                run = 1'b1; n = (k - 2) / 2;
            end else if (k < 172) begin
                run = 1'b0; n = 80;
            end else begin
                run = 1'b1; n = 80 + (k - 172) / 2;
            end
            pulse_ok = (k % 2 == 0) && ((k >= 2 && k <= 162) || k >= 174);
            eh = n % 8;
            ev = (n / 8) % 5;
            a  = run && eh < 4 && ev < 2;
            n_total++;
            if ({if_s0.x, if_s0.y} !== {10'(eh), 10'(ev)})
                $display("FAIL drop_pos k=%0d got x=%0d y=%0d want x=%0d y=%0d", k, if_s0.x, if_s0.y, eh, ev);
            else n_pass++;
            sync_exp = {a, !(run && (eh == 5 || eh == 6)), !(run && ev == 3), a};
            n_total++;
            if ({if_s0.active, if_s0.hs, if_s0.vs, if_s0.data_enable} !== sync_exp)
                $display("FAIL drop_sync k=%0d got %b want %b", k,
                         {if_s0.active, if_s0.hs, if_s0.vs, if_s0.data_enable}, sync_exp);
            else n_pass++;
            str_exp = {pulse_ok && n > 0 && (n % 8 == 0), pulse_ok && n > 0 && (n % 40 == 0), 16'(n / 40)};
            n_total++;
            if ({if_s0.line_start, if_s0.next_frame, if_s0.frame_count} !== str_exp)
                $display("FAIL drop_frame k=%0d got ls=%b nf=%b fc=%0d want ls=%b nf=%b fc=%0d", k,
                         if_s0.line_start, if_s0.next_frame, if_s0.frame_count, str_exp[17], str_exp[16],
                         str_exp[15:0]);
            else n_pass++;
            if (k == 122) enable = 1'b0;
            if (k == 170) enable = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_async_reset();
        test_small_pd0();
        test_pipe_delay();
        test_polarity();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
